status_decoder: RTL and testbench

Receive-side counterpart of the core's 32-bit status word generation. Sits on the core's output data stream and forwards data words downstream unchanged. It consumes the status word that closes every command, decodes it into success, failure or malformed, and holds a registered report until acknowledged. A watchdog flags a missing status word.

---
 rtl/status_decoder.sv | 129 ++++++++++++
 tb/tb_status_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/status_decoder.sv
// Receive-side status word decoder: forwards command data unchanged, then
// decodes the closing 32-bit status word into a registered report held until ack.
module status_decoder #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        nodata,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        st_valid,
  output logic        st_fail,
  output logic        st_err,
  output logic        st_timeout,
  input  logic        st_ack
);

  typedef enum logic [1:0] {
    PASS,
    WAIT_STATUS,
    REPORT
  } state_t;

  localparam logic [3:0] CODE_SUCCESS = 4'b1110;
  localparam logic [3:0] CODE_FAILURE = 4'b1111;
  // Count value whose increment lands on 2^TIMEOUT_W-1.
  localparam logic [TIMEOUT_W-1:0] WD_PRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state, state_nx;
  logic [TIMEOUT_W-1:0] wd, wd_nx;
  logic                 valid_nx, fail_nx, err_nx, timeout_nx;
  logic [3:0]           code;
  logic                 dec_fail, dec_err;

  assign code     = in_data[31:28];
  assign dec_fail = (code == CODE_FAILURE);
  assign dec_err  = ((code != CODE_SUCCESS) && (code != CODE_FAILURE)) || (|in_data[27:0]);

  always_comb begin
    state_nx   = state;
    wd_nx      = wd;
    valid_nx   = st_valid;
    fail_nx    = st_fail;
    err_nx     = st_err;
    timeout_nx = st_timeout;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = in_data;

    unique case (state)
      PASS: begin
        out_last = in_last;
        if (nodata) begin
          state_nx = WAIT_STATUS;
          wd_nx    = '0;
        end else begin
          in_ready  = out_ready;
          out_valid = in_valid;
          if (in_valid && out_ready && in_last) begin
            state_nx = WAIT_STATUS;
            wd_nx    = '0;
          end
        end
      end

      WAIT_STATUS: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx   = REPORT;
          valid_nx   = 1'b1;
          fail_nx    = dec_fail;
          err_nx     = dec_err;
          timeout_nx = 1'b0;
        end else begin
          wd_nx = wd + TIMEOUT_W'(1);
          if (wd == WD_PRE) begin
            state_nx   = REPORT;
            valid_nx   = 1'b1;
            fail_nx    = 1'b0;
            err_nx     = 1'b0;
            timeout_nx = 1'b1;
          end
        end
      end

      REPORT: begin
        if (st_ack) begin
          state_nx   = PASS;
          wd_nx      = '0;
          valid_nx   = 1'b0;
          fail_nx    = 1'b0;
          err_nx     = 1'b0;
          timeout_nx = 1'b0;
        end
      end

      default: begin
        state_nx = PASS;
        wd_nx    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PASS;
      wd         <= '0;
      st_valid   <= 1'b0;
      st_fail    <= 1'b0;
      st_err     <= 1'b0;
      st_timeout <= 1'b0;
    end else begin
      state      <= state_nx;
      wd         <= wd_nx;
      st_valid   <= valid_nx;
      st_fail    <= fail_nx;
      st_err     <= err_nx;
      st_timeout <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_status_decoder.sv
// Directed bench for status_decoder with a 4-bit watchdog (timeout after 15 idle cycles).
module tb_status_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid, in_last, in_ready, nodata;
  logic [31:0] out_data;
  logic        out_valid, out_last, out_ready;
  logic        st_valid, st_fail, st_err, st_timeout, st_ack;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  status_decoder #(.TIMEOUT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .nodata    (nodata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .st_valid  (st_valid),
    .st_fail   (st_fail),
    .st_err    (st_err),
    .st_timeout(st_timeout),
    .st_ack    (st_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    nodata   = 1'b0;
    st_ack   = 1'b0;
    in_data  = '0;
  endtask

  task automatic chk_report(input string tag, input logic v, input logic f,
                            input logic e, input logic t);
    chk({tag, "_valid"},   32'(st_valid),   32'(v));
    chk({tag, "_fail"},    32'(st_fail),    32'(f));
    chk({tag, "_err"},     32'(st_err),     32'(e));
    chk({tag, "_timeout"}, 32'(st_timeout), 32'(t));
  endtask

  // nodata-initiated command whose status word is w; acks and confirms return to PASS.
  task automatic status_case(input string tag, input logic [31:0] w,
                             input logic f, input logic e);
    idle();
    nodata = 1'b1;
    tick();
    nodata   = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    #1 chk({tag, "_wait_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_wait_noout"}, 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    #1 chk_report(tag, 1'b1, f, e, 1'b0);
    st_ack = 1'b1;
    tick();
    st_ack = 1'b0;
    #1 chk({tag, "_ack_clear"}, 32'(st_valid), 32'd0);
    chk({tag, "_pass_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle();

    // Reset state
    tick();
    chk_report("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Data then success
    in_valid = 1'b1; in_data = 32'h1111_1111;
    #1 chk("d1_data", out_data, 32'h1111_1111);
    chk("d1_valid", 32'(out_valid), 32'd1);
    chk("d1_last", 32'(out_last), 32'd0);
    tick();
    in_data = 32'h2222_2222;
    #1 chk("d2_data", out_data, 32'h2222_2222);
    tick();
    in_data = 32'h3333_3333; in_last = 1'b1;
    #1 chk("d3_data", out_data, 32'h3333_3333);
    chk("d3_last", 32'(out_last), 32'd1);
    chk("d3_valid", 32'(out_valid), 32'd1);
    tick();
    in_data = 32'hE000_0000; in_last = 1'b0;
    #1 chk("ok_wait_ready", 32'(in_ready), 32'd1);
    chk("ok_not_fwd", 32'(out_valid), 32'd0);
    chk("ok_not_yet", 32'(st_valid), 32'd0);
    tick();
    in_data = 32'h7777_7777;  // ignored while reporting
    #1 chk_report("ok", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rep_ready", 32'(in_ready), 32'd0);
    chk("rep_noout", 32'(out_valid), 32'd0);
    tick();
    #1 chk("rep_hold", 32'(st_valid), 32'd1);
    in_valid = 1'b0; st_ack = 1'b1;
    tick();
    st_ack = 1'b0;
    #1 chk("ok_ack_clear", 32'(st_valid), 32'd0);

    // nodata has priority over a pending last data word
    in_valid = 1'b1; in_last = 1'b1; in_data = 32'hDEAD_BEEF; nodata = 1'b1;
    #1 chk("nd_ready", 32'(in_ready), 32'd0);
    chk("nd_noout", 32'(out_valid), 32'd0);
    tick();
    nodata = 1'b0; in_last = 1'b0; in_data = 32'hF000_0000;
    tick();
    in_valid = 1'b0;
    #1 chk_report("nd_fail", 1'b1, 1'b1, 1'b0, 1'b0);
    st_ack = 1'b1;
    tick();
    st_ack = 1'b0; in_valid = 1'b1; in_data = 32'h0BAD_F00D;
    #1 chk("nd_resume_valid", 32'(out_valid), 32'd1);
    chk("nd_resume_data", out_data, 32'h0BAD_F00D);
    tick();

    // Malformed status words
    status_case("bad_code", 32'hA000_0000, 1'b0, 1'b1);
    status_case("bad_low",  32'hE000_0001, 1'b0, 1'b1);
    status_case("fail_low", 32'hF000_0010, 1'b1, 1'b1);

    // Backpressure: out_ready 1,0,0,1
    in_valid = 1'b1; in_data = 32'hAAAA_0001; out_ready = 1'b1;
    #1 chk("bp0_ready", 32'(in_ready), 32'd1);
    chk("bp0_data", out_data, 32'hAAAA_0001);
    tick();
    in_data = 32'hAAAA_0002; out_ready = 1'b0;
    #1 chk("bp1_ready", 32'(in_ready), 32'd0);
    chk("bp1_data", out_data, 32'hAAAA_0002);
    tick();
    #1 chk("bp2_ready", 32'(in_ready), 32'd0);
    chk("bp2_data", out_data, 32'hAAAA_0002);
    tick();
    out_ready = 1'b1; in_last = 1'b1;
    #1 chk("bp3_ready", 32'(in_ready), 32'd1);
    chk("bp3_data", out_data, 32'hAAAA_0002);
    chk("bp3_last", 32'(out_last), 32'd1);
    tick();
    in_last = 1'b0; in_data = 32'hE000_0000;
    #1 chk("bp_wait_noout", 32'(out_valid), 32'd0);
    tick();
    in_data = 32'hF000_0000;  // ignored in REPORT, must not alter flags
    tick();
    #1 chk_report("bp_rep", 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0; st_ack = 1'b1;
    tick();
    st_ack = 1'b0;

    // Watchdog timeout after 15 idle cycles
    nodata = 1'b1;
    tick();
    nodata = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    #1 chk("wd14_noreport", 32'(st_valid), 32'd0);
    tick();
    #1 chk_report("wd15", 1'b1, 1'b0, 1'b0, 1'b1);
    st_ack = 1'b1;
    tick();
    st_ack = 1'b0; in_valid = 1'b1; in_data = 32'hE000_0000;
    #1 chk("late_status_fwd", 32'(out_valid), 32'd1);
    chk("late_status_data", out_data, 32'hE000_0000);
    chk("late_clear", 32'(st_timeout), 32'd0);
    tick();

    // Status word exactly on cycle 15 wins
    in_valid = 1'b0; nodata = 1'b1;
    tick();
    nodata = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    in_valid = 1'b1; in_data = 32'hE000_0000;
    tick();
    in_valid = 1'b0;
    #1 chk_report("wd_edge", 1'b1, 1'b0, 1'b0, 1'b0);
    st_ack = 1'b1;
    tick();
    st_ack = 1'b0;

    // Reset while in REPORT
    nodata = 1'b1;
    tick();
    nodata = 1'b0; in_valid = 1'b1; in_data = 32'hF000_0010;
    tick();
    in_valid = 1'b0;
    #1 chk_report("pre_rst", 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1 chk_report("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1; in_valid = 1'b1; in_data = 32'h5A5A_5A5A;
    #1 chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_data", out_data, 32'h5A5A_5A5A);
    tick();
    in_valid = 1'b0;
    #1 chk("post_rst_nostatus", 32'(st_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
